player_motion_ctrl: RTL and testbench
=====================================

Name: player_motion_ctrl

Overview:
- Upstream neighbour of the VGA display stage.
- Parses PS/2 scan-code bytes into a held-arrow-key state.
- Steps the player sprite's top-left coordinate once per movement tick, clamped to the visible area.
- Drives the player0_x / player0_y buses that the display stage consumes.

Parameters:
- TICK_DIV, 2000000: clock cycles per movement tick (>=2).
- STEP, 1: pixels moved per tick.
- X_MAX, 608: largest legal x (640 minus 32-pixel sprite width).
- Y_MAX, 448: largest legal y (480 minus 32-pixel sprite height).
- X_INIT, 0: x after reset.
- Y_INIT, 0: y after reset.

Ports:
- clock  in  1  system clock; all state on its rising edge.
- reset  in  1  asynchronous, active-high; clears all state immediately.
- ps2_key_data  in  8  last received PS/2 byte.
- ps2_key_pressed  in  1  one-cycle strobe; ps2_key_data is valid and new this cycle.
- player0_x  out  32  x position, zero-extended from 10 bits.
- player0_y  out  32  y position, zero-extended from 9 bits.
- dir  out  2  held direction: 0 up, 1 right, 2 down, 3 left.
- moving  out  1  1 while an arrow key is held.
- tick  out  1  one-cycle pulse at each movement tick.

Behaviour:
- Reset values: player0_x=X_INIT, player0_y=Y_INIT, dir=0, moving=0, tick=0, tick counter=0, parser state=IDLE.
- Tick counter: counts 0..TICK_DIV-1. tick is registered and is 1 in the cycle after the counter holds TICK_DIV-1; the counter wraps to 0 at that edge. Period is exactly TICK_DIV cycles.
- Parser FSM advances only on cycles where ps2_key_pressed=1. States IDLE, EXT, EXT_BRK, BRK.
  - IDLE: E0->EXT; F0->BRK; any other byte->IDLE, ignored.
  - EXT: F0->EXT_BRK; 75/74/72/6B->make of up/right/down/left, then IDLE; anything else->IDLE.
  - EXT_BRK: any byte->IDLE; if the byte is an arrow code matching the currently held dir with moving=1, clear moving.
  - BRK: any byte->IDLE, no effect; non-extended break codes are swallowed.
- Arrow codes are also accepted without the E0 prefix in IDLE (make only), for keyboards in set-2 legacy mode.
- Make: dir<=code, moving<=1. Last make wins; a break of a non-held key is ignored.
- Motion: in the cycle tick=1 with moving=1, the position updates at that edge using the dir/moving values registered before the edge.
  - A key byte arriving in the same cycle affects only the next tick.
  - up: y-=STEP; down: y+=STEP; left: x-=STEP; right: x+=STEP.
- Arithmetic in 11-bit signed. Results below 0 clamp to 0; above X_MAX/Y_MAX clamp to the max. Position never leaves [0,X_MAX]x[0,Y_MAX].
- Asserting reset mid-tick or mid-sequence (e.g. in EXT) discards the partial sequence and the counter immediately.
- Outputs are registered; the upper bits of player0_x[31:10] and player0_y[31:9] are always 0.

Optional Feature:
- WRAP_AROUND_EN defined: tunnel mode.
  - Moving left from x<STEP gives x=X_MAX; moving right past X_MAX gives x=0.
  - Vertical axis wraps the same way with 0 and Y_MAX.
- Undefined: saturating clamp as above.
- Parser and tick timing are identical in both builds.

Test Plan:
- Reset, TICK_DIV=4 -> x=0, y=0, moving=0; tick pulses every 4th cycle; releasing reset mid-count restarts the count at 0.
- Bytes E0,74 -> dir=1, moving=1; after 3 ticks x=3, y=0; then E0,F0,74 -> moving=0, x stays 3 over 5 further ticks.
- Hold E0,75 from y=2 with STEP=1 for 5 ticks -> y goes 1,0,0,0,0. With WRAP_AROUND_EN defined -> 1,0,448,447,446.
- Hold right, then E0,6B (left) without releasing right; then E0,F0,74 -> dir=3 and moving stays 1 after the stale right-break; x decrements on each tick.
- Byte E0 strobed in the same cycle tick=1 while right is held -> x increments by STEP; parser is in EXT. Next byte 12 -> parser returns to IDLE, dir unchanged.
- Bytes F0,75 (non-extended break) and E0,1C (non-arrow) -> no change to dir, moving or position; FSM ends in IDLE.

Source files
------------

// File: rtl/player_motion_ctrl_if.sv
// Key-in / position-out bus between the PS/2 front end, the motion controller
// and the VGA display stage.
//   ps2_key_data/ps2_key_pressed : received PS/2 byte and its one-cycle strobe
//   player0_x/player0_y          : sprite top-left coordinate (zero-extended)
//   dir/moving/tick              : held direction, key-held flag, tick pulse
// master: drives key bytes, consumes position. slave: the motion controller.
interface player_motion_ctrl_if;
  logic [7:0]  ps2_key_data;
  logic        ps2_key_pressed;
  logic [31:0] player0_x;
  logic [31:0] player0_y;
  logic [1:0]  dir;
  logic        moving;
  logic        tick;

  modport master (
    output ps2_key_data, ps2_key_pressed,
    input  player0_x, player0_y, dir, moving, tick
  );

  modport slave (
    input  ps2_key_data, ps2_key_pressed,
    output player0_x, player0_y, dir, moving, tick
  );
endinterface

// File: rtl/player_motion_ctrl.sv
// Player motion controller: parses PS/2 arrow-key make/break sequences into a
// held direction and steps the sprite position once per movement tick,
// keeping it inside [0,X_MAX] x [0,Y_MAX].
// Ports:
//   clock  : rising-edge system clock
//   reset  : asynchronous active-high reset
//   bus    : player_motion_ctrl_if.slave (key bytes in; position, dir,
//            moving, tick out; all outputs registered)
// Build option: define WRAP_AROUND_EN for tunnel mode (edges wrap instead of
// saturating). Parser and tick timing are the same in both builds.
module player_motion_ctrl #(
  parameter int unsigned TICK_DIV = 2000000,
  parameter int unsigned STEP     = 1,
  parameter int unsigned X_MAX    = 608,
  parameter int unsigned Y_MAX    = 448,
  parameter int unsigned X_INIT   = 0,
  parameter int unsigned Y_INIT   = 0
) (
  input  logic                  clock,
  input  logic                  reset,
  player_motion_ctrl_if.slave   bus
);

  localparam int unsigned XW = 10;
  localparam int unsigned YW = 9;
  localparam int unsigned AW = 11;
  localparam int unsigned OW = 32;
  localparam int unsigned CW = $clog2(TICK_DIV);

  localparam logic signed [AW-1:0] STEP_S = AW'(STEP);
  localparam logic signed [AW-1:0] XMAX_S = AW'(X_MAX);
  localparam logic signed [AW-1:0] YMAX_S = AW'(Y_MAX);

  typedef enum logic [1:0] {IDLE, EXT, EXT_BRK, BRK} pstate_t;

  pstate_t          st_q;
  logic [CW-1:0]    cnt_q;
  logic             tick_q;
  logic [1:0]       dir_q;
  logic             moving_q;
  logic [XW-1:0]    x_q;
  logic [YW-1:0]    y_q;

  logic             is_arrow_c;
  logic [1:0]       arrow_dir_c;
  logic signed [AW-1:0] x_sum_c;
  logic signed [AW-1:0] y_sum_c;
  logic [XW-1:0]    x_nxt_c;
  logic [YW-1:0]    y_nxt_c;

  // Arrow scan code to direction (same codes with or without the E0 prefix)
  always_comb begin
    is_arrow_c  = 1'b1;
    arrow_dir_c = 2'd0;
    case (bus.ps2_key_data)
      8'h75:   arrow_dir_c = 2'd0;
      8'h74:   arrow_dir_c = 2'd1;
      8'h72:   arrow_dir_c = 2'd2;
      8'h6B:   arrow_dir_c = 2'd3;
      default: is_arrow_c  = 1'b0;
    endcase
  end

  // Candidate position one step along dir_q; only the moving axis changes
  always_comb begin
    x_sum_c = $signed({1'b0, x_q});
    y_sum_c = $signed({2'b00, y_q});
    case (dir_q)
      2'd0:    y_sum_c = $signed({2'b00, y_q}) - STEP_S;
      2'd1:    x_sum_c = $signed({1'b0, x_q}) + STEP_S;
      2'd2:    y_sum_c = $signed({2'b00, y_q}) + STEP_S;
      default: x_sum_c = $signed({1'b0, x_q}) - STEP_S;
    endcase
`ifdef WRAP_AROUND_EN
    if (x_sum_c < 0)           x_nxt_c = XW'(X_MAX);
    else if (x_sum_c > XMAX_S) x_nxt_c = '0;
    else                       x_nxt_c = x_sum_c[XW-1:0];
    if (y_sum_c < 0)           y_nxt_c = YW'(Y_MAX);
    else if (y_sum_c > YMAX_S) y_nxt_c = '0;
    else                       y_nxt_c = y_sum_c[YW-1:0];
`else
    if (x_sum_c < 0)           x_nxt_c = '0;
    else if (x_sum_c > XMAX_S) x_nxt_c = XW'(X_MAX);
    else                       x_nxt_c = x_sum_c[XW-1:0];
    if (y_sum_c < 0)           y_nxt_c = '0;
    else if (y_sum_c > YMAX_S) y_nxt_c = YW'(Y_MAX);
    else                       y_nxt_c = y_sum_c[YW-1:0];
`endif
  end

  // Tick divider, key-sequence parser and position register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      st_q     <= IDLE;
      cnt_q    <= '0;
      tick_q   <= 1'b0;
      dir_q    <= 2'd0;
      moving_q <= 1'b0;
      x_q      <= XW'(X_INIT);
      y_q      <= YW'(Y_INIT);
    end else begin
      if (cnt_q == CW'(TICK_DIV - 1)) begin
        cnt_q  <= '0;
        tick_q <= 1'b1;
      end else begin
        cnt_q  <= cnt_q + CW'(1);
        tick_q <= 1'b0;
      end

      // Uses dir/moving from before this edge; a same-cycle key waits a tick
      if (tick_q && moving_q) begin
        x_q <= x_nxt_c;
        y_q <= y_nxt_c;
      end

      if (bus.ps2_key_pressed) begin
        case (st_q)
          IDLE: begin
            if (bus.ps2_key_data == 8'hE0)      st_q <= EXT;
            else if (bus.ps2_key_data == 8'hF0) st_q <= BRK;
            else if (is_arrow_c) begin
              // Legacy un-prefixed arrow make
              dir_q    <= arrow_dir_c;
              moving_q <= 1'b1;
            end
          end
          EXT: begin
            if (bus.ps2_key_data == 8'hF0) st_q <= EXT_BRK;
            else begin
              st_q <= IDLE;
              if (is_arrow_c) begin
                dir_q    <= arrow_dir_c;
                moving_q <= 1'b1;
              end
            end
          end
          EXT_BRK: begin
            st_q <= IDLE;
            // Releasing a key other than the held one is stale; ignore it
            if (is_arrow_c && (arrow_dir_c == dir_q) && moving_q)
              moving_q <= 1'b0;
          end
          default: st_q <= IDLE;
        endcase
      end
    end
  end

  assign bus.player0_x = OW'(x_q);
  assign bus.player0_y = OW'(y_q);
  assign bus.dir       = dir_q;
  assign bus.moving    = moving_q;
  assign bus.tick      = tick_q;

endmodule

// File: tb/tb_player_motion_ctrl.sv
// Bench for player_motion_ctrl: a key-sequence/position model checked against
// the DUT every cycle, plus hand-computed spot values.
module tb_player_motion_ctrl;

  localparam int TD = 4;
  localparam int ST = 1;
  localparam int XM = 608;
  localparam int YM = 448;

  logic clock = 1'b0;
  logic reset = 1'b1;
  player_motion_ctrl_if bus ();

  player_motion_ctrl #(
    .TICK_DIV(TD), .STEP(ST), .X_MAX(XM), .Y_MAX(YM), .X_INIT(0), .Y_INIT(0)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d t=%0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int m_x, m_y, m_dir, m_phase, nx, ny, code;
  bit m_mov, m_tick, e0_seen, f0_seen;

  function automatic int arrow_of(input logic [7:0] b);
    case (b)
      8'h75: return 0;
      8'h74: return 1;
      8'h72: return 2;
      8'h6B: return 3;
      default: return -1;
    endcase
  endfunction

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      m_x = 0; m_y = 0; m_dir = 0; m_mov = 0;
      m_phase = 0; m_tick = 0; e0_seen = 0; f0_seen = 0;
    end else begin
      if (m_tick && m_mov) begin
        nx = m_x; ny = m_y;
        if (m_dir == 0) ny = ny - ST;
        else if (m_dir == 1) nx = nx + ST;
        else if (m_dir == 2) ny = ny + ST;
        else nx = nx - ST;
`ifdef WRAP_AROUND_EN
        if (nx < 0) nx = XM; else if (nx > XM) nx = 0;
        if (ny < 0) ny = YM; else if (ny > YM) ny = 0;
`else
        if (nx < 0) nx = 0; else if (nx > XM) nx = XM;
        if (ny < 0) ny = 0; else if (ny > YM) ny = YM;
`endif
        m_x = nx; m_y = ny;
      end
      if (bus.ps2_key_pressed) begin
        code = arrow_of(bus.ps2_key_data);
        if (f0_seen) begin
          if (e0_seen && code >= 0 && code == m_dir && m_mov) m_mov = 0;
          e0_seen = 0; f0_seen = 0;
        end else if (e0_seen) begin
          if (bus.ps2_key_data == 8'hF0) f0_seen = 1;
          else begin
            if (code >= 0) begin m_dir = code; m_mov = 1; end
            e0_seen = 0;
          end
        end else begin
          if (bus.ps2_key_data == 8'hE0) e0_seen = 1;
          else if (bus.ps2_key_data == 8'hF0) f0_seen = 1;
          else if (code >= 0) begin m_dir = code; m_mov = 1; end
        end
      end
      m_phase++;
      m_tick = (m_phase % TD) == 0;
    end
  end

  // Per-cycle comparison against the model
  always @(negedge clock) begin
    if (!reset) begin
      chk("x", bus.player0_x, m_x);
      chk("y", bus.player0_y, m_y);
      chk("dir", bus.dir, m_dir);
      chk("moving", bus.moving, m_mov);
      chk("tick", bus.tick, m_tick);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic nstep();
    @(negedge clock);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    bus.ps2_key_data    = b;
    bus.ps2_key_pressed = 1'b1;
    nstep();
    bus.ps2_key_pressed = 1'b0;
  endtask

  task automatic do_reset();
    nstep();
    reset = 1'b1;
    nstep();
    nstep();
    reset = 1'b0;
  endtask

  // Wait for n ticks, then one more cycle so the move has landed
  task automatic wait_ticks(input int n);
    int seen = 0;
    int cyc = 0;
    while (seen < n && cyc < TD * n + 8) begin
      nstep();
      cyc++;
      if (m_tick) seen++;
    end
    chk("tick_timeout", seen, n);
    nstep();
  endtask

  int exp_y[5];
  int cyc;

  initial begin
    bus.ps2_key_data    = 8'h00;
    bus.ps2_key_pressed = 1'b0;
    nstep();
    // Reset values while reset is held
    chk("rst_x", bus.player0_x, 0);
    chk("rst_y", bus.player0_y, 0);
    chk("rst_moving", bus.moving, 0);
    chk("rst_tick", bus.tick, 0);
    nstep();
    reset = 1'b0;

    // Tick every 4th cycle; reset mid-count restarts the count
    for (int k = 1; k <= 10; k++) begin
      nstep();
      chk("tick_phase", bus.tick, (k % TD) == 0);
    end
    reset = 1'b1;
    nstep();
    reset = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      nstep();
      chk("tick_restart", bus.tick, k == 4);
    end

    // Right for 3 ticks, then release; position holds
    do_reset();
    send(8'hE0); send(8'h74);
    chk("right_dir", bus.dir, 1);
    chk("right_moving", bus.moving, 1);
    wait_ticks(3);
    chk("right_x3", bus.player0_x, 3);
    chk("right_y0", bus.player0_y, 0);
    send(8'hE0); send(8'hF0); send(8'h74);
    chk("release_moving", bus.moving, 0);
    wait_ticks(5);
    chk("release_x_hold", bus.player0_x, 3);

    // Down to y=2, then up into the top edge
    do_reset();
    send(8'hE0); send(8'h72);
    wait_ticks(2);
    chk("down_y2", bus.player0_y, 2);
    send(8'hE0); send(8'h75);
`ifdef WRAP_AROUND_EN
    exp_y = '{1, 0, 448, 447, 446};
`else
    exp_y = '{1, 0, 0, 0, 0};
`endif
    for (int i = 0; i < 5; i++) begin
      wait_ticks(1);
      chk("up_edge_y", bus.player0_y, exp_y[i]);
    end

    // Left while right held; stale right-break is ignored
    do_reset();
    send(8'hE0); send(8'h74);
    wait_ticks(5);
    chk("hold_right_x5", bus.player0_x, 5);
    send(8'hE0); send(8'h6B);
    send(8'hE0); send(8'hF0); send(8'h74);
    chk("stale_dir", bus.dir, 3);
    chk("stale_moving", bus.moving, 1);
    wait_ticks(2);
    chk("left_x2", bus.player0_x, 2);

    // E0 arriving in the tick cycle
    do_reset();
    send(8'hE0); send(8'h74);
    cyc = 0;
    while (!m_tick && cyc < 2 * TD) begin
      nstep();
      cyc++;
    end
    chk("tick_found", m_tick, 1);
    bus.ps2_key_data    = 8'hE0;
    bus.ps2_key_pressed = 1'b1;
    nstep();
    bus.ps2_key_pressed = 1'b0;
    chk("same_cycle_x", bus.player0_x, 1);
    send(8'h12);
    chk("ext_other_dir", bus.dir, 1);
    chk("ext_other_moving", bus.moving, 1);
    send(8'h6B);
    chk("idle_legacy_left", bus.dir, 3);

    // Non-extended break and non-arrow extended code have no effect
    do_reset();
    send(8'hF0); send(8'h75);
    send(8'hE0); send(8'h1C);
    chk("noop_dir", bus.dir, 0);
    chk("noop_moving", bus.moving, 0);
    wait_ticks(1);
    chk("noop_x", bus.player0_x, 0);
    chk("noop_y", bus.player0_y, 0);
    send(8'h72);
    chk("after_noop_dir", bus.dir, 2);
    chk("after_noop_moving", bus.moving, 1);

    // Right edge boundary
    do_reset();
    send(8'hE0); send(8'h74);
    wait_ticks(610);
`ifdef WRAP_AROUND_EN
    chk("x_edge", bus.player0_x, 1);
`else
    chk("x_edge", bus.player0_x, 608);
`endif

    nstep();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
